// File: rtl/rs_alu_pkg.sv
// Shared widths, defaults and entry layout for the ALU reservation station.
// Also holds the common CDB snoop used both at issue (bypass) and at wake-up.
package rs_alu_pkg;

  localparam int OP_WIDTH     = 4;
  localparam int VAL_WIDTH    = 32;
  localparam int ADDR_WIDTH   = 32;
  localparam int ROB_ID_WIDTH = 4;
  localparam int ROB_SIZE     = 16;
  localparam int RS_ENTRIES   = 8;
  localparam int TAG_WIDTH    = ROB_ID_WIDTH + 1;

  typedef enum logic [OP_WIDTH-1:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_OR  = 4'd3,
    OP_XOR = 4'd4,
    OP_SLL = 4'd5,
    OP_SRL = 4'd6,
    OP_SLT = 4'd7
  } alu_op_e;

  typedef struct packed {
    logic                  busy;
    logic [OP_WIDTH-1:0]   op;
    logic [TAG_WIDTH-1:0]  lab1;
    logic [TAG_WIDTH-1:0]  lab2;
    logic [VAL_WIDTH-1:0]  val1;
    logic [VAL_WIDTH-1:0]  val2;
    logic                  rdy1;
    logic                  rdy2;
    logic [VAL_WIDTH-1:0]  imm;
    logic [ADDR_WIDTH-1:0] pc;
    logic [TAG_WIDTH-1:0]  tag;
  } rs_entry_t;

  // Returns {ready, value}; an already-ready operand passes through, otherwise
  // the ALU CDB is checked before the load CDB so it wins a label collision.
  function automatic logic [VAL_WIDTH:0] snoop(
    input logic                 rdy,
    input logic [TAG_WIDTH-1:0] lab,
    input logic [VAL_WIDTH-1:0] val,
    input logic                 c_en,
    input logic [TAG_WIDTH-1:0] c_lab,
    input logic [VAL_WIDTH-1:0] c_val,
    input logic                 l_en,
    input logic [TAG_WIDTH-1:0] l_lab,
    input logic [VAL_WIDTH-1:0] l_val
  );
    if (rdy)                      return {1'b1, val};
    else if (c_en && c_lab == lab) return {1'b1, c_val};
    else if (l_en && l_lab == lab) return {1'b1, l_val};
    else                          return {1'b0, val};
  endfunction

endpackage

// File: rtl/rs_pick.sv
// Lowest-index priority encoder; used for both free-slot and ready-slot choice.
module rs_pick #(
  parameter int N  = 8,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  output logic          found,
  output logic [IW-1:0] idx
);

  always_comb begin
    found = |req;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) idx = IW'(i);
    end
  end

endmodule

// File: rtl/rs_alu.sv
// ALU reservation station: issue into a free entry, snoop both CDBs for
// operands, and dispatch the lowest ready entry with a one-cycle alu_en pulse.
module rs_alu
  import rs_alu_pkg::*;
#(
  parameter int RS_SIZE = RS_ENTRIES
) (
  input  logic                  clk,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  flush,
  input  logic                  iss_en,
  input  logic [OP_WIDTH-1:0]   iss_op,
  input  logic [TAG_WIDTH-1:0]  iss_lab1,
  input  logic [TAG_WIDTH-1:0]  iss_lab2,
  input  logic [VAL_WIDTH-1:0]  iss_val1,
  input  logic [VAL_WIDTH-1:0]  iss_val2,
  input  logic                  iss_rdy1,
  input  logic                  iss_rdy2,
  input  logic [VAL_WIDTH-1:0]  iss_imm,
  input  logic [ADDR_WIDTH-1:0] iss_pc,
  input  logic [TAG_WIDTH-1:0]  iss_tag,
  input  logic                  cdb_en,
  input  logic [TAG_WIDTH-1:0]  cdb_lab,
  input  logic [VAL_WIDTH-1:0]  cdb_val,
  input  logic                  lsb_cdb_en,
  input  logic [TAG_WIDTH-1:0]  lsb_cdb_lab,
  input  logic [VAL_WIDTH-1:0]  lsb_cdb_val,
  output logic                  rs_full,
  output logic                  alu_en,
  output logic [OP_WIDTH-1:0]   alu_op,
  output logic [VAL_WIDTH-1:0]  alu_a,
  output logic [VAL_WIDTH-1:0]  alu_b,
  output logic [VAL_WIDTH-1:0]  alu_imm,
  output logic [ADDR_WIDTH-1:0] alu_pc,
  output logic [TAG_WIDTH-1:0]  alu_tag
);

  localparam int IW = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

  rs_entry_t ent_q [RS_SIZE];
  rs_entry_t ent_d [RS_SIZE];

  logic                  alu_en_q,  alu_en_d;
  logic [OP_WIDTH-1:0]   alu_op_q,  alu_op_d;
  logic [VAL_WIDTH-1:0]  alu_a_q,   alu_a_d;
  logic [VAL_WIDTH-1:0]  alu_b_q,   alu_b_d;
  logic [VAL_WIDTH-1:0]  alu_imm_q, alu_imm_d;
  logic [ADDR_WIDTH-1:0] alu_pc_q,  alu_pc_d;
  logic [TAG_WIDTH-1:0]  alu_tag_q, alu_tag_d;

  logic [RS_SIZE-1:0] busy_vec;
  logic [RS_SIZE-1:0] free_vec;
  logic [RS_SIZE-1:0] ready_vec;
  logic               free_found, disp_found;
  logic [IW-1:0]      free_idx, disp_idx;

  generate
    for (genvar gi = 0; gi < RS_SIZE; gi++) begin : g_vec
      assign busy_vec[gi]  = ent_q[gi].busy;
      assign ready_vec[gi] = ent_q[gi].busy & ent_q[gi].rdy1 & ent_q[gi].rdy2;
    end
  endgenerate

  assign free_vec = ~busy_vec;
  assign rs_full  = &busy_vec;

  rs_pick #(.N(RS_SIZE), .IW(IW)) u_free_pick (
    .req   (free_vec),
    .found (free_found),
    .idx   (free_idx)
  );

  rs_pick #(.N(RS_SIZE), .IW(IW)) u_ready_pick (
    .req   (ready_vec),
    .found (disp_found),
    .idx   (disp_idx)
  );

  logic [VAL_WIDTH:0] iss_op1, iss_op2;

  // Issue-cycle bypass: an operand not ready at issue may still catch a CDB.
  assign iss_op1 = snoop(iss_rdy1 || (iss_lab1 == '0), iss_lab1, iss_val1,
                         cdb_en, cdb_lab, cdb_val, lsb_cdb_en, lsb_cdb_lab, lsb_cdb_val);
  assign iss_op2 = snoop(iss_rdy2 || (iss_lab2 == '0), iss_lab2, iss_val2,
                         cdb_en, cdb_lab, cdb_val, lsb_cdb_en, lsb_cdb_lab, lsb_cdb_val);

  always_comb begin
    ent_d     = ent_q;
    alu_en_d  = alu_en_q;
    alu_op_d  = alu_op_q;
    alu_a_d   = alu_a_q;
    alu_b_d   = alu_b_q;
    alu_imm_d = alu_imm_q;
    alu_pc_d  = alu_pc_q;
    alu_tag_d = alu_tag_q;

    if (rdy_in) begin
      if (flush) begin
        for (int i = 0; i < RS_SIZE; i++) ent_d[i].busy = 1'b0;
        alu_en_d = 1'b0;
      end else begin
        for (int i = 0; i < RS_SIZE; i++) begin
          if (ent_q[i].busy) begin
            {ent_d[i].rdy1, ent_d[i].val1} = snoop(ent_q[i].rdy1, ent_q[i].lab1, ent_q[i].val1,
              cdb_en, cdb_lab, cdb_val, lsb_cdb_en, lsb_cdb_lab, lsb_cdb_val);
            {ent_d[i].rdy2, ent_d[i].val2} = snoop(ent_q[i].rdy2, ent_q[i].lab2, ent_q[i].val2,
              cdb_en, cdb_lab, cdb_val, lsb_cdb_en, lsb_cdb_lab, lsb_cdb_val);
          end
        end

        // Selection uses pre-edge state, so a just-woken entry waits a cycle.
        alu_en_d = disp_found;
        if (disp_found) begin
          alu_op_d  = ent_q[disp_idx].op;
          alu_a_d   = ent_q[disp_idx].val1;
          alu_b_d   = ent_q[disp_idx].val2;
          alu_imm_d = ent_q[disp_idx].imm;
          alu_pc_d  = ent_q[disp_idx].pc;
          alu_tag_d = ent_q[disp_idx].tag;
          ent_d[disp_idx].busy = 1'b0;
        end

        // free_idx is never the dispatched slot since it was idle pre-edge.
        if (iss_en && !rs_full && free_found) begin
          ent_d[free_idx].busy = 1'b1;
          ent_d[free_idx].op   = iss_op;
          ent_d[free_idx].lab1 = iss_lab1;
          ent_d[free_idx].lab2 = iss_lab2;
          ent_d[free_idx].rdy1 = iss_op1[VAL_WIDTH];
          ent_d[free_idx].val1 = iss_op1[VAL_WIDTH-1:0];
          ent_d[free_idx].rdy2 = iss_op2[VAL_WIDTH];
          ent_d[free_idx].val2 = iss_op2[VAL_WIDTH-1:0];
          ent_d[free_idx].imm  = iss_imm;
          ent_d[free_idx].pc   = iss_pc;
          ent_d[free_idx].tag  = iss_tag;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < RS_SIZE; i++) ent_q[i] <= '0;
      alu_en_q  <= 1'b0;
      alu_op_q  <= '0;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_imm_q <= '0;
      alu_pc_q  <= '0;
      alu_tag_q <= '0;
    end else begin
      for (int i = 0; i < RS_SIZE; i++) ent_q[i] <= ent_d[i];
      alu_en_q  <= alu_en_d;
      alu_op_q  <= alu_op_d;
      alu_a_q   <= alu_a_d;
      alu_b_q   <= alu_b_d;
      alu_imm_q <= alu_imm_d;
      alu_pc_q  <= alu_pc_d;
      alu_tag_q <= alu_tag_d;
    end
  end

  assign alu_en  = alu_en_q;
  assign alu_op  = alu_op_q;
  assign alu_a   = alu_a_q;
  assign alu_b   = alu_b_q;
  assign alu_imm = alu_imm_q;
  assign alu_pc  = alu_pc_q;
  assign alu_tag = alu_tag_q;

endmodule

// File: tb/tb_rs_alu.sv
// Directed bench for rs_alu: issue, CDB wake-up/bypass, fill, flush, stall, reset.
module tb_rs_alu;
  import rs_alu_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst_in, rdy_in, flush, iss_en;
  logic [OP_WIDTH-1:0]   iss_op;
  logic [TAG_WIDTH-1:0]  iss_lab1, iss_lab2, iss_tag;
  logic [VAL_WIDTH-1:0]  iss_val1, iss_val2, iss_imm;
  logic                  iss_rdy1, iss_rdy2;
  logic [ADDR_WIDTH-1:0] iss_pc;
  logic                  cdb_en, lsb_cdb_en;
  logic [TAG_WIDTH-1:0]  cdb_lab, lsb_cdb_lab;
  logic [VAL_WIDTH-1:0]  cdb_val, lsb_cdb_val;
  logic                  rs_full, alu_en;
  logic [OP_WIDTH-1:0]   alu_op;
  logic [VAL_WIDTH-1:0]  alu_a, alu_b, alu_imm;
  logic [ADDR_WIDTH-1:0] alu_pc;
  logic [TAG_WIDTH-1:0]  alu_tag;

  int checks   = 0;
  int failures = 0;

  rs_alu #(.RS_SIZE(8)) dut (
    .clk(clk), .rst_in(rst_in), .rdy_in(rdy_in), .flush(flush),
    .iss_en(iss_en), .iss_op(iss_op), .iss_lab1(iss_lab1), .iss_lab2(iss_lab2),
    .iss_val1(iss_val1), .iss_val2(iss_val2), .iss_rdy1(iss_rdy1), .iss_rdy2(iss_rdy2),
    .iss_imm(iss_imm), .iss_pc(iss_pc), .iss_tag(iss_tag),
    .cdb_en(cdb_en), .cdb_lab(cdb_lab), .cdb_val(cdb_val),
    .lsb_cdb_en(lsb_cdb_en), .lsb_cdb_lab(lsb_cdb_lab), .lsb_cdb_val(lsb_cdb_val),
    .rs_full(rs_full), .alu_en(alu_en), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_imm(alu_imm), .alu_pc(alu_pc), .alu_tag(alu_tag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; everything after this runs 1 time unit past posedge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    iss_en = 0; flush = 0; cdb_en = 0; lsb_cdb_en = 0;
  endtask

  task automatic issue(input int op, input int lab1, input int val1, input bit r1,
                       input int lab2, input int val2, input bit r2, input int tag);
    iss_en   = 1;
    iss_op   = OP_WIDTH'(op);
    iss_lab1 = TAG_WIDTH'(lab1);  iss_val1 = VAL_WIDTH'(val1);  iss_rdy1 = r1;
    iss_lab2 = TAG_WIDTH'(lab2);  iss_val2 = VAL_WIDTH'(val2);  iss_rdy2 = r2;
    iss_tag  = TAG_WIDTH'(tag);
    iss_imm  = VAL_WIDTH'(tag * 16);
    iss_pc   = ADDR_WIDTH'(32'h1000 + tag * 4);
  endtask

  task automatic cdb(input int lab, input int val);
    cdb_en = 1; cdb_lab = TAG_WIDTH'(lab); cdb_val = VAL_WIDTH'(val);
  endtask

  task automatic lsb(input int lab, input int val);
    lsb_cdb_en = 1; lsb_cdb_lab = TAG_WIDTH'(lab); lsb_cdb_val = VAL_WIDTH'(val);
  endtask

  initial begin
    rst_in = 0; rdy_in = 1; idle();
    issue(0, 0, 0, 0, 0, 0, 0, 0); iss_en = 0;
    cdb_lab = '0; cdb_val = '0; lsb_cdb_lab = '0; lsb_cdb_val = '0;

    #3;
    chk("reset_alu_en", alu_en, 0);
    chk("reset_rs_full", rs_full, 0);
    chk("reset_alu_a", alu_a, 0);
    chk("reset_alu_tag", alu_tag, 0);
    step(); step();
    rst_in = 1;

    // Simple ready issue
    issue(OP_ADD, 0, 5, 0, 0, 7, 0, 3);
    step(); idle();
    chk("add_issue_edge_en", alu_en, 0);
    step();
    $display("txn add: en=%0d a=%0h b=%0h tag=%0d", alu_en, alu_a, alu_b, alu_tag);
    chk("add_en", alu_en, 1);
    chk("add_a", alu_a, 5);
    chk("add_b", alu_b, 7);
    chk("add_tag", alu_tag, 3);
    chk("add_imm", alu_imm, 3 * 16);
    chk("add_pc", alu_pc, 32'h1000 + 12);
    step();
    chk("add_pulse_end", alu_en, 0);
    chk("add_hold_a", alu_a, 5);

    // ALU CDB wake-up two cycles after issue
    issue(OP_SUB, 2, 0, 0, 0, 1, 1, 5);
    step(); idle();
    cdb(3, 32'h99);
    step(); idle();
    chk("wake_wrong_label", alu_en, 0);
    cdb(2, 32'h10);
    step(); idle();
    chk("wake_capture_edge", alu_en, 0);
    step();
    $display("txn wake: en=%0d a=%0h op=%0d tag=%0d", alu_en, alu_a, alu_op, alu_tag);
    chk("wake_en", alu_en, 1);
    chk("wake_a", alu_a, 32'h10);
    chk("wake_b", alu_b, 1);
    chk("wake_op", alu_op, OP_SUB);
    chk("wake_tag", alu_tag, 5);

    // Load CDB bypass in the issue cycle
    issue(OP_AND, 0, 2, 1, 4, 0, 0, 6);
    lsb(4, 32'h20);
    step(); idle();
    step();
    $display("txn bypass: en=%0d b=%0h tag=%0d", alu_en, alu_b, alu_tag);
    chk("bypass_en", alu_en, 1);
    chk("bypass_b", alu_b, 32'h20);
    chk("bypass_tag", alu_tag, 6);

    // Both CDBs carry the same label: ALU CDB wins
    issue(OP_OR, 7, 0, 0, 0, 3, 1, 7);
    step(); idle();
    cdb(7, 32'hAA);
    lsb(7, 32'hBB);
    step(); idle();
    step();
    $display("txn collide: en=%0d a=%0h", alu_en, alu_a);
    chk("collide_en", alu_en, 1);
    chk("collide_a", alu_a, 32'hAA);

    // Fill all entries waiting on tag 1
    for (int i = 0; i < 8; i++) begin
      issue(OP_XOR, 1, 0, 0, 0, 32'h30 + i, 1, 8 + i);
      step();
      if (i == 6) chk("fill_7_not_full", rs_full, 0);
    end
    idle();
    chk("fill_full", rs_full, 1);
    issue(OP_ADD, 0, 1, 1, 0, 1, 1, 16);
    step(); idle();
    chk("full_ignore_en", alu_en, 0);
    chk("full_still_full", rs_full, 1);
    cdb(1, 32'h55);
    step(); idle();
    chk("drain_capture_edge", alu_en, 0);
    for (int i = 0; i < 8; i++) begin
      step();
      $display("txn drain %0d: en=%0d tag=%0d a=%0h b=%0h", i, alu_en, alu_tag, alu_a, alu_b);
      chk("drain_en", alu_en, 1);
      chk("drain_tag", alu_tag, 8 + i);
      chk("drain_a", alu_a, 32'h55);
      chk("drain_b", alu_b, 32'h30 + i);
    end
    step();
    chk("drain_done_en", alu_en, 0);
    chk("drain_done_full", rs_full, 0);

    // Issue and dispatch in the same cycle
    issue(OP_ADD, 0, 1, 1, 0, 1, 1, 2);
    step();
    issue(OP_ADD, 0, 2, 1, 0, 2, 1, 3);
    step(); idle();
    chk("overlap_first_en", alu_en, 1);
    chk("overlap_first_tag", alu_tag, 2);
    step();
    chk("overlap_second_en", alu_en, 1);
    chk("overlap_second_tag", alu_tag, 3);
    step();

    // Flush with three busy entries, one of them ready
    issue(OP_ADD, 9, 0, 0, 0, 1, 1, 2);
    step();
    issue(OP_ADD, 9, 0, 0, 0, 1, 1, 3);
    step();
    issue(OP_ADD, 0, 1, 1, 0, 2, 1, 4);
    step(); idle();
    flush = 1;
    issue(OP_ADD, 0, 1, 1, 0, 2, 1, 5);
    step(); idle();
    $display("txn flush: en=%0d full=%0d", alu_en, rs_full);
    chk("flush_en", alu_en, 0);
    chk("flush_full", rs_full, 0);
    cdb(9, 32'h66);
    step(); idle();
    for (int i = 0; i < 3; i++) begin
      step();
      chk("flush_no_dispatch", alu_en, 0);
    end

    // Stall with rdy_in low
    issue(OP_ADD, 11, 0, 0, 0, 1, 1, 12);
    step();
    issue(OP_ADD, 0, 3, 1, 0, 4, 1, 10);
    step(); idle();
    rdy_in = 0;
    cdb(11, 32'h77);
    step(); idle();
    chk("stall_en_0", alu_en, 0);
    step();
    chk("stall_en_1", alu_en, 0);
    step();
    chk("stall_en_2", alu_en, 0);
    rdy_in = 1;
    step();
    $display("txn resume: en=%0d tag=%0d a=%0h", alu_en, alu_tag, alu_a);
    chk("resume_en", alu_en, 1);
    chk("resume_tag", alu_tag, 10);
    chk("resume_a", alu_a, 3);
    step();
    chk("stall_no_capture", alu_en, 0);
    cdb(11, 32'h88);
    step(); idle();
    step();
    chk("late_wake_en", alu_en, 1);
    chk("late_wake_a", alu_a, 32'h88);
    chk("late_wake_tag", alu_tag, 12);

    // Asynchronous reset between edges
    issue(OP_ADD, 13, 0, 0, 0, 1, 1, 14);
    step(); idle();
    #2 rst_in = 0;
    #1;
    $display("txn async reset: en=%0d a=%0h tag=%0d full=%0d", alu_en, alu_a, alu_tag, rs_full);
    chk("areset_en", alu_en, 0);
    chk("areset_a", alu_a, 0);
    chk("areset_tag", alu_tag, 0);
    chk("areset_full", rs_full, 0);
    #2 rst_in = 1;
    cdb(13, 32'h44);
    step(); idle();
    step();
    chk("areset_entry_gone", alu_en, 0);
    issue(OP_ADD, 0, 9, 1, 0, 8, 1, 1);
    step(); idle();
    step();
    chk("post_reset_en", alu_en, 1);
    chk("post_reset_a", alu_a, 9);
    chk("post_reset_tag", alu_tag, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rs_alu.md
RS_ALU -- requirements
Module: rs_alu

Interface
REQ-001 Parameter RS_SIZE, default 8, number of reservation-station entries.
REQ-002 clk  in  1  sole clock, all state on rising edge.
REQ-003 rst_in  in  1  asynchronous, active-low reset.
REQ-004 rdy_in  in  1  global enable; low freezes all state and outputs.
REQ-005 flush  in  1  mispredict flush from the reorder buffer.
REQ-006 iss_en  in  1  issue strobe from the decoder.
REQ-007 iss_op  in  OP_WIDTH  operation code.
REQ-008 iss_lab1/iss_lab2  in  ROB_ID_WIDTH+1  source producer tags; 0 means no dependency.
REQ-009 iss_val1/iss_val2  in  VAL_WIDTH  source values; valid when the matching iss_rdy bit is set.
REQ-010 iss_rdy1/iss_rdy2  in  1  source value ready.
REQ-011 iss_imm, iss_pc  in  VAL_WIDTH, ADDR_WIDTH  immediate and instruction PC.
REQ-012 iss_tag  in  ROB_ID_WIDTH+1  destination ROB tag, range 1..ROB_SIZE.
REQ-013 cdb_en, cdb_lab, cdb_val  in  1, ROB_ID_WIDTH+1, VAL_WIDTH  ALU result broadcast.
REQ-014 lsb_cdb_en, lsb_cdb_lab, lsb_cdb_val  in  1, ROB_ID_WIDTH+1, VAL_WIDTH  load result broadcast.
REQ-015 rs_full  out  1  all entries busy; combinational from the busy vector.
REQ-016 alu_en  out  1  dispatch valid, one-cycle pulse.
REQ-017 alu_op, alu_a, alu_b, alu_imm, alu_pc, alu_tag  out  widths as issue fields  dispatched operation.

Function
REQ-018 Each entry SHALL hold busy, op, two tags, two values, two ready bits, imm, pc, and dest tag.
REQ-019 On iss_en with rs_full low, the lowest-index non-busy entry, chosen from pre-edge state, SHALL be written and marked busy.
REQ-020 iss_en while rs_full is high SHALL be ignored, with no state change.
REQ-021 An operand SHALL be marked ready at issue if its tag is 0 or its iss_rdy bit is 1.
REQ-022 An operand not yet ready whose tag equals cdb_lab (cdb_en) or lsb_cdb_lab (lsb_cdb_en) in the issue cycle SHALL capture that value and be ready (bypass).
REQ-023 Each cycle, every busy entry's waiting operand SHALL capture the value from any enabled CDB whose label matches its tag, and set ready.
REQ-024 If both CDBs carry the same label, the ALU CDB SHALL win.
REQ-025 Select: the lowest-index busy entry with both operands ready at the pre-edge state SHALL be dispatched.
REQ-026 Dispatch SHALL register the alu_* fields, pulse alu_en for exactly one cycle, and clear that entry's busy bit on the same edge; latency is one cycle from ready to alu_en.
REQ-027 An entry written or woken on edge N SHALL be dispatchable no earlier than edge N+1.
REQ-028 Issue and dispatch in the same cycle SHALL both occur; the freed slot SHALL NOT be reused in that cycle.
REQ-029 When no entry is selectable, alu_en SHALL be 0 and the alu_* fields SHALL hold.
REQ-030 flush with rdy_in high SHALL clear all busy bits and alu_en on the next edge, overriding issue, wake-up and dispatch.
REQ-031 With rdy_in low, no entry, busy bit or output register SHALL change, including CDB captures.

Reset
REQ-032 rst_in low SHALL immediately clear all busy and ready bits and set alu_en=0, with alu_op/alu_a/alu_b/alu_imm/alu_pc/alu_tag=0, independent of clk.
REQ-033 Reset SHALL drive rs_full to 0, and the block SHALL accept issue on the first edge after rst_in rises.

Structure
REQ-034 OP_WIDTH, VAL_WIDTH, ADDR_WIDTH, ROB_ID_WIDTH, ROB_SIZE and RS_SIZE SHALL come from the shared util definitions file.
REQ-035 The only sub-module SHALL be rs_pick, a parameterised lowest-index priority encoder used for both the free-slot and ready-slot selection.

Verification
REQ-036 Scenario: issue ADD, lab1=0 val1=5, lab2=0 val2=7, tag=3 -> next edge alu_en=1, alu_a=5, alu_b=7, alu_tag=3, then alu_en=0.
REQ-037 Scenario: issue with lab1=2 unready; two cycles later cdb_en, cdb_lab=2, cdb_val=0x10 -> dispatch one edge later with alu_a=0x10.
REQ-038 Scenario: issue with lab2=4 while lsb_cdb_lab=4 in the same cycle -> operand captured, dispatch on the next edge.
REQ-039 Scenario: fill 8 entries all waiting on tag 1 -> rs_full=1 and a 9th iss_en is ignored; broadcast tag 1 -> entries dispatch in index order 0..7 on consecutive cycles.
REQ-040 Scenario: 3 busy entries then flush with rdy_in=1 -> no alu_en afterwards and rs_full=0; issue in the flush cycle is dropped.
REQ-041 Scenario: hold rdy_in=0 for 3 cycles with a ready entry and a CDB pulse -> no dispatch and no capture; dispatch resumes after rdy_in rises; rst_in low mid-run clears everything asynchronously.
